// File: rtl/varredura_matriz.sv
// varredura_matriz: row-multiplexed 8x8 LED scanner for the ball/paddle game.
// Define PLACAR_EN to add a score bar on rows 3 and 4 of the lose screen.
module varredura_matriz #(
   parameter int DIV_SCAN     = 1000,
   parameter int BLINK_FRAMES = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] posx,
   input  logic [2:0] posy,
   input  logic [2:0] raquete_cima,
   input  logic [2:0] raquete_baixo,
   input  logic       perdeu,
   input  logic       ganhou,
   input  logic [2:0] pontos,
   output logic [7:0] linha,
   output logic [7:0] coluna,
   output logic       quadro
);

   localparam int PW = (DIV_SCAN > 1) ? $clog2(DIV_SCAN) : 1;
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(DIV_SCAN - 1);
   localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_FRAMES - 1);

   typedef enum logic [1:0] {
      JOGO   = 2'd0,
      PERDEU = 2'd1,
      GANHOU = 2'd2
   } estado_t;

   estado_t       estado_q, estado_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [2:0]    row_q, row_d;
   logic [BW-1:0] blink_q, blink_d;
   logic          fase_q, fase_d;
   logic          carga_q, carga_d;
   logic [2:0]    px_q, px_d;
   logic [2:0]    py_q, py_d;
   logic [2:0]    rc_q, rc_d;
   logic [2:0]    rb_q, rb_d;
   logic [7:0]    linha_q, linha_d;
   logic [7:0]    coluna_q, coluna_d;
   logic          quadro_q, quadro_d;

   logic          fim_linha;
   logic          fronteira;
   logic          carrega;
   logic [2:0]    rc1;
   logic [2:0]    rb1;
   logic [7:0]    jogo_pat;
   logic [7:0]    pat;

`ifdef PLACAR_EN
   logic [2:0]    pts_q, pts_d;
   logic [7:0]    barra;
`else
   logic          unused_pontos;
   assign unused_pontos = ^pontos;
`endif

   assign rc1 = rc_q + 3'd1;
   assign rb1 = rb_q + 3'd1;

   always_comb begin
      jogo_pat = 8'h00;
      if (row_q == py_q)
         jogo_pat = jogo_pat | (8'd1 << px_q);
      if (row_q == 3'd7)
         jogo_pat = jogo_pat | (8'd1 << rc_q) | (8'd1 << rc1);
      if (row_q == 3'd0)
         jogo_pat = jogo_pat | (8'd1 << rb_q) | (8'd1 << rb1);
   end

`ifdef PLACAR_EN
   always_comb begin
      unique case (pts_q)
         3'd0:    barra = 8'h00;
         3'd1:    barra = 8'h01;
         3'd2:    barra = 8'h03;
         3'd3:    barra = 8'h07;
         3'd4:    barra = 8'h0F;
         default: barra = 8'h1F;
      endcase
   end
`endif

   always_comb begin
      pat = jogo_pat;
      unique case (estado_q)
         JOGO: pat = jogo_pat;
         PERDEU: begin
            pat = fase_q ? jogo_pat : 8'h00;
`ifdef PLACAR_EN
            if (row_q == 3'd3 || row_q == 3'd4)
               pat = pat | barra;
`endif
         end
         // checkerboard: row parity against fase picks the phase
         GANHOU:  pat = (row_q[0] ^ ~fase_q) ? 8'hAA : 8'h55;
         default: pat = jogo_pat;
      endcase
   end

   always_comb begin
      fim_linha = (presc_q == PRESC_MAX);
      fronteira = fim_linha && (row_q == 3'd7);
      carrega   = carga_q || fronteira;

      presc_d  = fim_linha ? '0 : presc_q + 1'b1;
      row_d    = fim_linha ? row_q + 3'd1 : row_q;
      blink_d  = blink_q;
      fase_d   = fase_q;
      estado_d = estado_q;
      carga_d  = 1'b0;
      px_d     = px_q;
      py_d     = py_q;
      rc_d     = rc_q;
      rb_d     = rb_q;
`ifdef PLACAR_EN
      pts_d    = pts_q;
`endif

      if (fronteira) begin
         if (blink_q == BLINK_MAX) begin
            blink_d = '0;
            fase_d  = ~fase_q;
         end else begin
            blink_d = blink_q + 1'b1;
         end
      end

      if (carrega) begin
         px_d = posx;
         py_d = posy;
         rc_d = raquete_cima;
         rb_d = raquete_baixo;
`ifdef PLACAR_EN
         pts_d = pontos;
`endif
         unique case (estado_q)
            JOGO: begin
               if (ganhou)
                  estado_d = GANHOU;
               else if (perdeu)
                  estado_d = PERDEU;
            end
            PERDEU: begin
               if (ganhou)
                  estado_d = GANHOU;
            end
            GANHOU:  estado_d = GANHOU;
            default: estado_d = JOGO;
         endcase
      end

      // snapshot is not valid yet during the load cycle
      linha_d  = carga_q ? 8'h00 : (8'd1 << row_q);
      coluna_d = carga_q ? 8'hFF : ~pat;
      quadro_d = fronteira;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         presc_q  <= '0;
         row_q    <= 3'd0;
         blink_q  <= '0;
         fase_q   <= 1'b1;
         estado_q <= JOGO;
         carga_q  <= 1'b1;
         px_q     <= 3'd0;
         py_q     <= 3'd0;
         rc_q     <= 3'd0;
         rb_q     <= 3'd0;
`ifdef PLACAR_EN
         pts_q    <= 3'd0;
`endif
         linha_q  <= 8'h00;
         coluna_q <= 8'hFF;
         quadro_q <= 1'b0;
      end else begin
         presc_q  <= presc_d;
         row_q    <= row_d;
         blink_q  <= blink_d;
         fase_q   <= fase_d;
         estado_q <= estado_d;
         carga_q  <= carga_d;
         px_q     <= px_d;
         py_q     <= py_d;
         rc_q     <= rc_d;
         rb_q     <= rb_d;
`ifdef PLACAR_EN
         pts_q    <= pts_d;
`endif
         linha_q  <= linha_d;
         coluna_q <= coluna_d;
         quadro_q <= quadro_d;
      end
   end

   assign linha  = linha_q;
   assign coluna = coluna_q;
   assign quadro = quadro_q;

endmodule

// File: tb/tb_varredura_matriz.sv
// Testbench for varredura_matriz: frame-level model checked every cycle
// plus directed literal checks of the display patterns.
module tb_varredura_matriz;

   localparam int DIV  = 4;
   localparam int BLK  = 2;
   localparam int FRM  = 8 * DIV;

   logic       clk;
   logic       reset;
   logic [2:0] posx, posy, cima, baixo, pontos;
   logic       perdeu, ganhou;
   logic [7:0] linha, coluna;
   logic       quadro;

   int errors = 0;
   int checks = 0;

   varredura_matriz #(
      .DIV_SCAN     (DIV),
      .BLINK_FRAMES (BLK)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .posx          (posx),
      .posy          (posy),
      .raquete_cima  (cima),
      .raquete_baixo (baixo),
      .perdeu        (perdeu),
      .ganhou        (ganhou),
      .pontos        (pontos),
      .linha         (linha),
      .coluna        (coluna),
      .quadro        (quadro)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // model state: k = clock edges since reset release
   int         k;
   int         st;
   bit         fs;
   int         bc;
   int         sx, sy, sc, sb, sp;
   bit         armed = 0;
   logic [7:0] e_linha, e_col;
   logic       e_q;

   function automatic logic [7:0] modelo(input int r);
      logic [7:0] v;
      bit on, jg;
      v = 8'h00;
      for (int c = 0; c < 8; c++) begin
         jg = (r == sy && c == sx)
            || (r == 7 && (c == sc || c == (sc + 1) % 8))
            || (r == 0 && (c == sb || c == (sb + 1) % 8));
         on = jg;
         if (st == 1) begin
            on = fs && jg;
`ifdef PLACAR_EN
            if ((r == 3 || r == 4) && c < ((sp > 5) ? 5 : sp))
               on = 1;
`endif
         end else if (st == 2) begin
            on = (((r + c) % 2) == 0) ^ !fs;
         end
         v[c] = on;
      end
      return v;
   endfunction

   task automatic carregar();
      sx = int'(posx);
      sy = int'(posy);
      sc = int'(cima);
      sb = int'(baixo);
      sp = int'(pontos);
      if (ganhou)
         st = 2;
      else if (perdeu && st == 0)
         st = 1;
   endtask

   always @(posedge clk) begin
      armed = 1;
      if (!reset) begin
         k = 0; st = 0; fs = 1; bc = 0;
         sx = 0; sy = 0; sc = 0; sb = 0; sp = 0;
         e_linha = 8'h00; e_col = 8'hFF; e_q = 0;
      end else if (k == 0) begin
         e_linha = 8'h00; e_col = 8'hFF; e_q = 0;
         carregar();
         k = 1;
      end else begin
         e_linha = 8'h01 << ((k / DIV) % 8);
         e_col = ~modelo((k / DIV) % 8);
         e_q = ((k % FRM) == FRM - 1);
         if (e_q) begin
            carregar();
            if (bc == BLK - 1) begin
               bc = 0;
               fs = !fs;
            end else begin
               bc++;
            end
         end
         k++;
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         checks++;
         if (linha !== e_linha || coluna !== e_col || quadro !== e_q) begin
            errors++;
            $display("FAIL scan t=%0t linha=%h exp %h coluna=%h exp %h quadro=%b exp %b",
                     $time, linha, e_linha, coluna, e_col, quadro, e_q);
         end
      end
   end

   task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   task automatic wait_row(input logic [7:0] l, input string nm);
      int n;
      n = 0;
      @(negedge clk);
      while (linha !== l && n < 80) begin
         @(negedge clk);
         n++;
      end
      if (linha !== l) begin
         errors++;
         checks++;
         $display("FAIL %s timeout linha=%h exp %h", nm, linha, l);
      end
   endtask

   task automatic wait_quadro();
      int n;
      n = 0;
      @(negedge clk);
      while (quadro !== 1'b1 && n < 80) begin
         @(negedge clk);
         n++;
      end
      if (quadro !== 1'b1) begin
         errors++;
         checks++;
         $display("FAIL quadro_timeout got=%b exp=1", quadro);
      end
   endtask

   initial begin
      int cnt;
      logic [7:0] r0;
      reset = 0; perdeu = 0; ganhou = 0; pontos = 3'd3;
      posx = 3'd4; posy = 3'd4; cima = 3'd3; baixo = 3'd2;
      repeat (3) @(negedge clk);
      chk("reset_linha", linha, 8'h00);
      chk("reset_coluna", coluna, 8'hFF);
      chk("reset_quadro", {7'd0, quadro}, 8'h00);
      reset = 1;

      wait_row(8'h01, "w_r0");  chk("base_r0", coluna, 8'hF3);
      wait_row(8'h02, "w_r1");  chk("base_r1", coluna, 8'hFF);
      wait_row(8'h10, "w_r4");  chk("base_r4", coluna, 8'hEF);
      wait_row(8'h80, "w_r7");  chk("base_r7", coluna, 8'hE7);

      cnt = 0;
      repeat (2 * FRM) begin
         @(negedge clk);
         if (quadro === 1'b1) cnt++;
      end
      chk("quadro_period", 8'(cnt), 8'd2);

      cima = 3'd7; baixo = 3'd7; posy = 3'd0; posx = 3'd3;
      wait_quadro();
      wait_row(8'h01, "w_wrap0"); chk("wrap_r0", coluna, 8'h76);
      wait_row(8'h80, "w_wrap7"); chk("wrap_r7", coluna, 8'h7E);

      posx = 3'd4; posy = 3'd4; cima = 3'd3; baixo = 3'd2;
      wait_quadro();
      wait_row(8'h04, "w_snap2");
      posx = 3'd6;
      wait_row(8'h10, "w_snap4a"); chk("snap_old", coluna, 8'hEF);
      wait_quadro();
      wait_row(8'h10, "w_snap4b"); chk("snap_new", coluna, 8'hBF);

      perdeu = 1;
      wait_quadro();
      perdeu = 0;
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         wait_row(8'h10, "w_perdeu");
         if (coluna[6] === 1'b1) cnt++;
         wait_quadro();
      end
      chk("perdeu_blank_frames", 8'(cnt), 8'd2);
      wait_row(8'h08, "w_placar");
`ifdef PLACAR_EN
      chk("placar_r3", coluna, 8'hF8);
`else
      chk("placar_r3", coluna, 8'hFF);
`endif

      ganhou = 1; perdeu = 1;
      wait_quadro();
      wait_row(8'h01, "w_g0");
      r0 = coluna;
      chk("ganhou_r0_ok", {7'd0, (r0 == 8'hAA || r0 == 8'h55)}, 8'h01);
      wait_row(8'h02, "w_g1");
      chk("ganhou_r1", coluna, ~r0);
      wait_quadro();
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         wait_row(8'h01, "w_gc");
         if (coluna === 8'hAA) cnt++;
         wait_quadro();
      end
      chk("ganhou_swap", 8'(cnt), 8'd2);

      wait_row(8'h04, "w_rst");
      reset = 0;
      @(negedge clk);
      chk("midreset_linha", linha, 8'h00);
      chk("midreset_coluna", coluna, 8'hFF);
      chk("midreset_quadro", {7'd0, quadro}, 8'h00);
      ganhou = 0; perdeu = 0; posx = 3'd6; posy = 3'd4;
      repeat (2) @(negedge clk);
      reset = 1;
      wait_row(8'h10, "w_back");
      chk("back_jogo_r4", coluna, 8'hBF);

      repeat (5) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/varredura_matriz.md
Name: varredura_matriz

Overview:
- Display-side consumer of the ball/paddle game state. Multiplexes the 8x8 LED matrix one row at a time, drawing the ball at (posx, posy), the top paddle on row 7 and the bottom paddle on row 0.
- Adds lose-blink and win-pattern screens.
- Inputs are snapshotted once per frame, so a ball step mid-scan never tears the image.
- Emits a one-cycle end-of-frame pulse that the game logic can use as a timebase.

Parameters:
- DIV_SCAN, 1000: clk cycles per displayed row (≥2).
- BLINK_FRAMES, 32: frames per blink/pattern half-period (≥1).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- posx  input  3  ball column
- posy  input  3  ball row
- raquete_cima  input  3  top paddle left column; occupies row 7, columns p and p+1 (mod 8)
- raquete_baixo  input  3  bottom paddle left column; occupies row 0, columns p and p+1 (mod 8)
- perdeu  input  1  game lost
- ganhou  input  1  game won
- pontos  input  3  score
- linha  output  8  row select, one-hot, active-high
- coluna  output  8  column drive, active-low (0 = LED on)
- quadro  output  1  one-cycle end-of-frame pulse

Behaviour:
- Reset (reset=0 at a clk edge):
  - presc=0, row=0, blink counter=0, fase=1, state=JOGO, carga=1.
  - Snapshot regs cleared.
  - linha=8'h00, coluna=8'hFF, quadro=0.
- presc counts 0..DIV_SCAN-1. At DIV_SCAN-1: presc<=0, row<=row+1, wrapping 7->0.
- Frame boundary (row==7 && presc==DIV_SCAN-1):
  - quadro<=1 for the next cycle only; otherwise quadro=0.
  - Snapshot posx, posy, raquete_cima, raquete_baixo, perdeu, ganhou, pontos.
  - Apply the state transition.
  - Blink counter increments; at BLINK_FRAMES-1 it clears and fase toggles.
- carga=1 (first cycle after reset): snapshot loaded and state evaluated as at a frame boundary; carga<=0. No quadro pulse, blink counter unchanged.
- States (evaluated only at snapshot loads, priority ganhou > perdeu):
  - JOGO -> GANHOU if ganhou; else JOGO -> PERDEU if perdeu.
  - PERDEU -> GANHOU if ganhou; PERDEU otherwise sticky.
  - GANHOU sticky.
  - Only reset returns to JOGO. Deasserting perdeu/ganhou has no effect.
- Row pattern P(r), bit c = column c, built from snapshot values:
  - JOGO: ball bit posx if r==posy, OR paddle bits p and p+1 (3-bit wrap) on row 7 (cima) / row 0 (baixo). Overlaps OR together.
  - PERDEU: JOGO pattern when fase=1; 8'h00 when fase=0.
  - GANHOU: 8'h55 on even rows and 8'hAA on odd rows when fase=1; swapped when fase=0.
- Outputs registered, one cycle latency: linha<=1<<row; coluna<=~P(row). linha is never zero except during reset and the first cycle after it.
- Out-of-range inputs cannot occur: 3-bit values cover the full matrix.
- Reset mid-frame takes effect at that edge; outputs are blanked immediately.

Optional Feature:
- Macro: PLACAR_EN
- Defined: in PERDEU, rows 3 and 4 always show a score bar, independent of fase:
  - Bits 0..pontos-1 set (pontos=0 -> none; values ≥ 5 show 5 LEDs).
  - Bar is ORed with the blink pattern.
- Undefined: PERDEU shows only the blinking JOGO pattern; the pontos input is unused.

Test Plan:
All scenarios use DIV_SCAN=4, BLINK_FRAMES=2 (row = 4 cycles, frame = 32 cycles).
- Reset held 3 cycles -> linha=00, coluna=FF, quadro=0. Release with posx=4, posy=4, cima=3, baixo=2 -> linha=01 window coluna=F3; linha=10 window coluna=EF; linha=80 window coluna=E7; other rows FF. quadro pulses every 32 cycles.
- Wrap: raquete_cima=7 -> row-7 window coluna=7E; raquete_baixo=7, posy=0, posx=3 -> row-0 window coluna=76.
- Snapshot: change posx 4->6 while row 2 is displayed -> row 4 still shows EF this frame; shows BF from the frame after quadro.
- perdeu=1 pulse mid-frame, then 0 -> pattern switches at the next boundary: 2 frames normal, 2 frames all FF, repeating; state never returns to JOGO.
- ganhou=1 and perdeu=1 together -> GANHOU: even rows coluna=AA, odd rows 55; swapped after 2 frames. Reset=0 mid-row -> next cycle linha=00, coluna=FF.
- PLACAR_EN, pontos=3, perdeu=1 -> rows 3 and 4 coluna=F8 in the fase=0 frames; row 3 shows F8 (with the ball, ANDed) in the visible frames.
